// File: rtl/excess3_pkg.sv
// excess3_pkg: Excess-3 code constants and the sequencer state type shared by encoder and decoder wrappers
package excess3_pkg;
    localparam logic [3:0] E3_OFFSET = 4'd3;
    localparam logic [3:0] E3_MIN    = 4'b0011;
    localparam logic [3:0] E3_MAX    = 4'b1100;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/excess3_digit_dec.sv
// excess3_digit_dec: combinational single-digit Excess-3 to BCD decoder
//   code : 4-bit Excess-3 code in
//   bcd  : decoded BCD digit, 0 for an invalid code
//   inv  : high when code is outside 0011..1100
module excess3_digit_dec
    import excess3_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] bcd,
    output logic       inv
);
    always_comb begin
        inv = code < E3_MIN || code > E3_MAX;
        bcd = inv ? 4'd0 : code - E3_OFFSET;
    end
endmodule

// File: rtl/excess3_to_bcd_seq.sv
// excess3_to_bcd_seq: multi-digit Excess-3 to BCD decoder, one digit per clock
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : input handshake, ready only in IDLE
//   e3_in               : packed Excess-3 word, digit k at [4k+3:4k]
//   out_valid/out_ready : output handshake, valid only in DONE
//   bcd_out, err_mask   : packed BCD result and per-digit invalid-code flags
//   err                 : OR of err_mask, registered on entry to DONE
module excess3_to_bcd_seq
    import excess3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] e3_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   err_mask,
    output logic                err
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [4*DIGITS-1:0] e3_q;
    logic [3:0] cur, dig_bcd;
    logic dig_inv, last;
    assign cur = e3_q[4*idx +: 4];
    assign last = idx == IW'(DIGITS - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    excess3_digit_dec u_dec (
        .code(cur),
        .bcd (dig_bcd),
        .inv (dig_inv)
    );
    always_comb begin
        state_nx = state;
        if (state == IDLE && in_valid)
            state_nx = CONV;
        else if (state == CONV && last)
            state_nx = DONE;
        else if (state == DONE && out_ready)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx      <= '0;
            e3_q     <= '0;
            bcd_out  <= '0;
            err_mask <= '0;
            err      <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            idx      <= '0;
            e3_q     <= e3_in;
            bcd_out  <= '0;
            err_mask <= '0;
            err      <= 1'b0;
        end else if (state == CONV) begin
            bcd_out[4*idx +: 4] <= dig_bcd;
            err_mask[idx]       <= dig_inv;
            idx                 <= last ? '0 : idx + 1'b1;
            // the last digit's flag is not in err_mask yet, so fold it in here
            if (last)
                err <= |err_mask | dig_inv;
        end
endmodule
